// File: rtl/ipg_pkg.sv
// Shared definitions for the IPG insert/extract path: block headers,
// replacement blocks, frame delimiter block types and the frame FSM encoding.
package ipg_pkg;

    localparam logic [1:0]  IPG_HDR     = 2'b00;
    localparam logic [1:0]  DATA_HDR    = 2'b01;
    localparam logic [1:0]  CTRL_HDR    = 2'b10;

    localparam logic [63:0] IDLE_BLOCK  = 64'h0000_0000_0000_001E;
    localparam logic [63:0] ERROR_BLOCK = 64'h1E3C_78F1_E3C7_8F1E;

    // Control block types that open a frame.
    localparam logic [7:0]  BT_START_0  = 8'h78;
    localparam logic [7:0]  BT_START_4A = 8'h33;
    localparam logic [7:0]  BT_START_4B = 8'h66;

    // Control block types that close a frame (terminate with 0..7 bytes).
    localparam logic [7:0]  BT_TERM_0   = 8'h87;
    localparam logic [7:0]  BT_TERM_1   = 8'h99;
    localparam logic [7:0]  BT_TERM_2   = 8'hAA;
    localparam logic [7:0]  BT_TERM_3   = 8'hB4;
    localparam logic [7:0]  BT_TERM_4   = 8'hCC;
    localparam logic [7:0]  BT_TERM_5   = 8'hD2;
    localparam logic [7:0]  BT_TERM_6   = 8'hE1;
    localparam logic [7:0]  BT_TERM_7   = 8'hFF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } frame_state_t;

    typedef struct packed {
        logic [1:0]  hdr;
        logic [63:0] data;
    } block_t;

    function automatic logic is_start(input logic [7:0] block_type);
        return block_type inside {BT_START_0, BT_START_4A, BT_START_4B};
    endfunction

    function automatic logic is_term(input logic [7:0] block_type);
        return block_type inside {BT_TERM_0, BT_TERM_1, BT_TERM_2, BT_TERM_3,
                                  BT_TERM_4, BT_TERM_5, BT_TERM_6, BT_TERM_7};
    endfunction

endpackage

// File: rtl/ipg_chunk_fifo.sv
// Synchronous chunk FIFO with occupancy count. A push into a full FIFO is
// accepted only when a pop frees an entry in the same cycle.
module ipg_chunk_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head entry is presented directly; zero while empty so nothing stale leaks out.
    assign rdata = empty ? '0 : mem[rd_ptr];

    // Storage write; pointers wrap naturally because DEPTH is a power of two.
    // NOTE: the storage array has no reset -- validity is tracked by count,
    // so clearing the pointers is enough and the array can map to RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ipg_rx_extract.sv
// RX-side IPG extraction: strips IPG blocks (hdr 00) from the decoded block
// stream, replaces them with idle or error blocks, and queues the chunks
// carried in inter-frame IPG blocks for a ready/valid consumer.
module ipg_rx_extract
    import ipg_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WIDTH  = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_THRESH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] encoded_rx_data,
    input  logic [HDR_WIDTH-1:0]  encoded_rx_hdr,
    output logic [DATA_WIDTH-1:0] proced_encoded_rx_data,
    output logic [HDR_WIDTH-1:0]  proced_encoded_rx_hdr,
    output logic [DATA_WIDTH-1:0] ipg_rx_chunk,
    output logic                  ipg_rx_valid,
    input  logic                  ipg_rx_ready,
    output logic                  ipg_rx_almost_full,
    output logic                  ipg_rx_overflow,
    output logic                  ipg_rx_bad_chunk
);

    localparam int          CW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] AF_CNT = CW'(AF_THRESH);

    frame_state_t    state;
    frame_state_t    state_next;
    block_t          out_next;
    logic            push;
    logic            pop;
    logic            bad_next;
    logic            is_ipg;
    logic            is_ctrl;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;

    assign is_ipg  = (encoded_rx_hdr == IPG_HDR);
    assign is_ctrl = (encoded_rx_hdr == CTRL_HDR);
    assign pop     = ipg_rx_valid && ipg_rx_ready;
    assign ipg_rx_valid = !fifo_empty;

    // Frame tracking and per-block decision: forward, substitute, or extract.
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        out_next   = '{hdr: encoded_rx_hdr, data: encoded_rx_data};
        push       = 1'b0;
        bad_next   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_ipg) begin
                    out_next = '{hdr: CTRL_HDR, data: IDLE_BLOCK};
                    push     = 1'b1;
                end else if (is_ctrl && is_start(encoded_rx_data[7:0])) begin
                    state_next = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (is_ipg) begin
                    out_next = '{hdr: CTRL_HDR, data: ERROR_BLOCK};
                    bad_next = 1'b1;
                end else if (is_ctrl && is_term(encoded_rx_data[7:0])) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // One-cycle registered datapath and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proced_encoded_rx_hdr  <= CTRL_HDR;
            proced_encoded_rx_data <= IDLE_BLOCK;
            ipg_rx_bad_chunk       <= 1'b0;
            ipg_rx_overflow        <= 1'b0;
            ipg_rx_almost_full     <= 1'b0;
        end else begin
            proced_encoded_rx_hdr  <= out_next.hdr;
            proced_encoded_rx_data <= out_next.data;
            ipg_rx_bad_chunk       <= bad_next;
            ipg_rx_overflow        <= push && fifo_full && !pop;
            ipg_rx_almost_full     <= (fifo_count >= AF_CNT);
        end
    end

    ipg_chunk_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (encoded_rx_data),
        .pop   (pop),
        .rdata (ipg_rx_chunk),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_ipg_rx_extract.sv
// Bench for ipg_rx_extract: directed scenarios followed by random block
// traffic, all compared against a queue-based reference model.
module tb_ipg_rx_extract;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] encoded_rx_data;
    logic [1:0]  encoded_rx_hdr;
    logic [63:0] proced_encoded_rx_data;
    logic [1:0]  proced_encoded_rx_hdr;
    logic [63:0] ipg_rx_chunk;
    logic        ipg_rx_valid;
    logic        ipg_rx_ready;
    logic        ipg_rx_almost_full;
    logic        ipg_rx_overflow;
    logic        ipg_rx_bad_chunk;

    int checks = 0;
    int errors = 0;

    // Reference model: chunk queue plus an in-frame flag.
    logic [63:0] mq[$];
    bit          in_frame;
    int          bad_seen;
    int          ovf_seen;
    int          af_first_sz;

    logic [7:0] start_types [3] = '{8'h78, 8'h33, 8'h66};
    logic [7:0] term_types  [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

    always #5 clk = ~clk;

    ipg_rx_extract #(
        .DATA_WIDTH (64),
        .HDR_WIDTH  (2),
        .FIFO_DEPTH (16),
        .AF_THRESH  (12)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .encoded_rx_data        (encoded_rx_data),
        .encoded_rx_hdr         (encoded_rx_hdr),
        .proced_encoded_rx_data (proced_encoded_rx_data),
        .proced_encoded_rx_hdr  (proced_encoded_rx_hdr),
        .ipg_rx_chunk           (ipg_rx_chunk),
        .ipg_rx_valid           (ipg_rx_valid),
        .ipg_rx_ready           (ipg_rx_ready),
        .ipg_rx_almost_full     (ipg_rx_almost_full),
        .ipg_rx_overflow        (ipg_rx_overflow),
        .ipg_rx_bad_chunk       (ipg_rx_bad_chunk)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one block for one cycle and compare everything the DUT shows afterwards.
    task automatic step(input logic [1:0] h, input logic [63:0] d, input logic rdy);
        logic [1:0]  e_hdr;
        logic [63:0] e_data;
        logic        e_bad;
        logic        e_ovf;
        logic        do_pop;
        logic        do_push;
        int          sz;
        @(negedge clk);
        encoded_rx_hdr  = h;
        encoded_rx_data = d;
        ipg_rx_ready    = rdy;
        sz      = mq.size();
        do_pop  = (sz > 0) && rdy;
        do_push = 1'b0;
        e_hdr   = h;
        e_data  = d;
        e_bad   = 1'b0;
        if (h == 2'b00) begin
            e_hdr = 2'b10;
            if (in_frame) begin
                e_data = 64'h1E3C_78F1_E3C7_8F1E;
                e_bad  = 1'b1;
            end else begin
                e_data  = 64'h0000_0000_0000_001E;
                do_push = 1'b1;
            end
        end else if (h == 2'b10) begin
            if (!in_frame && (d[7:0] inside {8'h78, 8'h33, 8'h66}))
                in_frame = 1'b1;
            else if (in_frame && (d[7:0] inside {8'h87, 8'h99, 8'hAA, 8'hB4,
                                                  8'hCC, 8'hD2, 8'hE1, 8'hFF}))
                in_frame = 1'b0;
        end
        e_ovf = do_push && (sz == 16) && !do_pop;
        @(posedge clk);
        #1;
        if (do_pop) void'(mq.pop_front());
        if (do_push && !e_ovf) mq.push_back(d);
        if (ipg_rx_bad_chunk === 1'b1) bad_seen++;
        if (ipg_rx_overflow === 1'b1) ovf_seen++;
        if (ipg_rx_almost_full === 1'b1 && af_first_sz < 0) af_first_sz = sz;
        chk("out_hdr",  {62'd0, proced_encoded_rx_hdr}, {62'd0, e_hdr});
        chk("out_data", proced_encoded_rx_data, e_data);
        chk("bad_chunk", {63'd0, ipg_rx_bad_chunk}, {63'd0, e_bad});
        chk("overflow", {63'd0, ipg_rx_overflow}, {63'd0, e_ovf});
        chk("valid", {63'd0, ipg_rx_valid}, {63'd0, mq.size() > 0});
        chk("chunk", ipg_rx_chunk, (mq.size() > 0) ? mq[0] : 64'd0);
        chk("almost_full", {63'd0, ipg_rx_almost_full}, {63'd0, sz >= 12});
        chk("count", 64'(dut.fifo_count), 64'(mq.size()));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b1;
        encoded_rx_hdr  = 2'b10;
        encoded_rx_data = 64'h0000_0000_0000_001E;
        ipg_rx_ready    = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_hdr", {62'd0, proced_encoded_rx_hdr}, 64'd2);
        chk("rst_data", proced_encoded_rx_data, 64'h1E);
        chk("rst_valid", {63'd0, ipg_rx_valid}, 64'd0);
        chk("rst_chunk", ipg_rx_chunk, 64'd0);
        chk("rst_af", {63'd0, ipg_rx_almost_full}, 64'd0);
        chk("rst_ovf", {63'd0, ipg_rx_overflow}, 64'd0);
        chk("rst_bad", {63'd0, ipg_rx_bad_chunk}, 64'd0);
        chk("rst_count", 64'(dut.fifo_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        in_frame = 1'b0;
    endtask

    initial begin
        logic [1:0]  h;
        logic [63:0] d;
        logic        rdy;
        rst             = 1'b1;
        encoded_rx_hdr  = 2'b10;
        encoded_rx_data = 64'h1E;
        ipg_rx_ready    = 1'b0;
        in_frame        = 1'b0;
        af_first_sz     = -1;

        do_reset();

        // IPG inside a frame becomes an error block and is not queued.
        bad_seen = 0;
        step(2'b10, 64'h5555_5555_5555_5578, 1'b1);
        step(2'b01, 64'hA5A5_0000_1111_2222, 1'b1);
        step(2'b00, 64'hDEAD_BEEF_0000_0001, 1'b1);
        step(2'b10, 64'h0000_0000_0000_0087, 1'b1);
        chk("frame_bad_once", 64'(bad_seen), 64'd1);
        chk("frame_fifo_empty", {63'd0, ipg_rx_valid}, 64'd0);

        // IPG between frames becomes idle and its chunk appears one cycle later.
        step(2'b00, 64'h0123_4567_89AB_CDEF, 1'b1);
        chk("idle_chunk", ipg_rx_chunk, 64'h0123_4567_89AB_CDEF);
        chk("idle_out", proced_encoded_rx_data, 64'h1E);
        step(2'b01, 64'h0, 1'b1);

        // Seventeen chunks with the consumer stalled, then drain in order.
        ovf_seen    = 0;
        af_first_sz = -1;
        for (int i = 1; i <= 17; i++) step(2'b00, 64'(i), 1'b0);
        chk("fill_ovf_once", 64'(ovf_seen), 64'd1);
        chk("fill_af_at_12", 64'(af_first_sz), 64'd12);
        for (int i = 1; i <= 16; i++) begin
            chk("drain_order", ipg_rx_chunk, 64'(i));
            step(2'b01, 64'hFFFF_0000_FFFF_0000, 1'b1);
        end
        chk("drain_empty", {63'd0, ipg_rx_valid}, 64'd0);

        // Full FIFO with a simultaneous pop accepts the new chunk.
        for (int i = 0; i < 16; i++) step(2'b00, 64'h100 + 64'(i), 1'b0);
        ovf_seen = 0;
        step(2'b00, 64'hCAFE, 1'b1);
        chk("full_pop_no_ovf", 64'(ovf_seen), 64'd0);
        chk("full_pop_count", 64'(dut.fifo_count), 64'd16);
        for (int i = 0; i < 16; i++) step(2'b11, 64'(i), 1'b1);

        // Reset mid-frame with chunks queued discards everything.
        for (int i = 0; i < 5; i++) step(2'b00, 64'h200 + 64'(i), 1'b0);
        step(2'b10, 64'h33, 1'b0);
        do_reset();
        step(2'b00, 64'hBEEF_0042, 1'b0);
        chk("post_rst_accept", 64'(dut.fifo_count), 64'd1);
        chk("post_rst_chunk", ipg_rx_chunk, 64'hBEEF_0042);

        // Random traffic: a stall-heavy phase, then a drain-heavy phase.
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin h = 2'b00; d = {$urandom, $urandom}; end
                3: begin h = 2'b10; d = {$urandom, $urandom}; d[7:0] = start_types[$urandom_range(0, 2)]; end
                4: begin h = 2'b10; d = {$urandom, $urandom}; d[7:0] = term_types[$urandom_range(0, 7)]; end
                5: begin h = 2'b10; d = {$urandom, $urandom}; end
                6, 7: begin h = 2'b01; d = {$urandom, $urandom}; end
                default: begin h = 2'b11; d = {$urandom, $urandom}; end
            endcase
            rdy = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(h, d, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
